// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared FSM states and constants for pipeline control
package pipeline_ctrl_pkg;
    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MEM_WAIT    = 2'd1,
        ERR_RECOVER = 2'd2
    } state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int DEF_MEM_TIMEOUT = 64;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q, cnt_d;
    // next count, held once every bit is set
    always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    // count register
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign cnt = cnt_q;
endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: stall/flush sequencer for the 5-stage pipeline
module hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int TO_W        = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             exmem_branch_taken,
    input  logic             exmem_mem_access,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);
    state_t          state_q, state_d;
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;
    logic            load_use, flush_inc, stall_inc;
    // control outputs and next state; memory freeze outranks branch flush outranks load-use
    always_comb begin
        load_use = idex_mem_read && idex_rd != REG_ZERO &&
                   (idex_rd == id_rs1 || (id_uses_rs2 && idex_rd == id_rs2));
        state_d = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d = mem_err_q;
        dmem_req = 1'b0;
        pc_en = 1'b1;
        ifid_en = 1'b1;
        idex_en = 1'b1;
        exmem_en = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        exmem_flush = 1'b0;
        memwb_bubble = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                dmem_req = exmem_mem_access;
                if (!dmem_ready && (state_q == MEM_WAIT || exmem_mem_access)) begin
                    pc_en = 1'b0;
                    ifid_en = 1'b0;
                    idex_en = 1'b0;
                    exmem_en = 1'b0;
                    memwb_bubble = 1'b1;
                    if (state_q == RUN) begin
                        state_d = MEM_WAIT;
                        wait_cnt_d = TO_W'(1);
                    end else if (wait_cnt_q == TO_W'(MEM_TIMEOUT)) begin
                        state_d = ERR_RECOVER;
                        mem_err_d = 1'b1;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = RUN;
                    wait_cnt_d = '0;
                    if (exmem_branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        pc_en = 1'b0;
                        ifid_en = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
            end
            ERR_RECOVER: begin
                exmem_flush = 1'b1;
                memwb_bubble = 1'b1;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
        if (reset) begin
            pc_en = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
            exmem_en = 1'b0;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            exmem_flush = 1'b0;
            memwb_bubble = 1'b0;
            dmem_req = 1'b0;
            flush_inc = 1'b0;
        end
        stall_inc = !pc_en && !reset;
    end
    // state, wait counter and sticky error register
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= RUN;
            wait_cnt_q <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q <= mem_err_d;
        end
    sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .reset(reset), .inc(stall_inc), .cnt(stall_cnt));
    sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .reset(reset), .inc(flush_inc), .cnt(flush_cnt));
    assign state = state_q;
    assign mem_err = mem_err_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed checks of stall, flush, memory wait and timeout sequencing
module tb_hazard_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, idex_rd;
    logic       id_uses_rs2, idex_mem_read, exmem_branch_taken, exmem_mem_access, dmem_ready;
    logic       dmem_req, pc_en, ifid_en, idex_en, exmem_en;
    logic       ifid_flush, idex_flush, exmem_flush, memwb_bubble, mem_err;
    logic [1:0] state, stall_cnt, flush_cnt;
    int         checks = 0;
    int         errors = 0;

    hazard_controller #(.CNT_W(2), .MEM_TIMEOUT(4), .TO_W(3)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .idex_mem_read(idex_mem_read), .idex_rd(idex_rd), .exmem_branch_taken(exmem_branch_taken),
        .exmem_mem_access(exmem_mem_access), .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_bubble(memwb_bubble), .state(state), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; idex_rd = 0; id_uses_rs2 = 0; idex_mem_read = 0;
        exmem_branch_taken = 0; exmem_mem_access = 0; dmem_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        idle();
        reset = 1;
        #2;
        reset = 0;
        cyc();
    endtask

    initial begin
        reset = 1;
        idle();
        #12;
        chk("rst_pc_en", int'(pc_en), 0);
        chk("rst_exmem_en", int'(exmem_en), 0);
        chk("rst_dmem_req", int'(dmem_req), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_stall_cnt", int'(stall_cnt), 0);
        reset = 0;
        #1;
        chk("run_pc_en", int'(pc_en), 1);
        chk("run_idex_en", int'(idex_en), 1);
        // load-use on rs1
        cyc();
        idex_mem_read = 1; idex_rd = 5; id_rs1 = 5;
        #1;
        chk("lu_pc_en", int'(pc_en), 0);
        chk("lu_ifid_en", int'(ifid_en), 0);
        chk("lu_idex_flush", int'(idex_flush), 1);
        chk("lu_idex_en", int'(idex_en), 1);
        cyc();
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        idex_rd = 0; id_rs1 = 0;
        #1;
        chk("x0_pc_en", int'(pc_en), 1);
        chk("x0_idex_flush", int'(idex_flush), 0);
        cyc();
        chk("x0_stall_cnt", int'(stall_cnt), 1);
        // rs2 gating
        idex_rd = 7; id_rs2 = 7; id_rs1 = 1; id_uses_rs2 = 0;
        #1;
        chk("rs2off_pc_en", int'(pc_en), 1);
        cyc();
        id_uses_rs2 = 1;
        #1;
        chk("rs2on_pc_en", int'(pc_en), 0);
        chk("rs2on_idex_flush", int'(idex_flush), 1);
        cyc();
        chk("rs2on_stall_cnt", int'(stall_cnt), 2);
        // branch over load-use
        exmem_branch_taken = 1;
        #1;
        chk("br_ifid_flush", int'(ifid_flush), 1);
        chk("br_idex_flush", int'(idex_flush), 1);
        chk("br_exmem_flush", int'(exmem_flush), 1);
        chk("br_pc_en", int'(pc_en), 1);
        cyc();
        chk("br_flush_cnt", int'(flush_cnt), 1);
        chk("br_stall_cnt", int'(stall_cnt), 2);
        // memory wait, 3 cycles low then ready with a branch on release
        pulse_reset();
        chk("rst2_flush_cnt", int'(flush_cnt), 0);
        exmem_mem_access = 1;
        #1;
        chk("mw0_dmem_req", int'(dmem_req), 1);
        chk("mw0_pc_en", int'(pc_en), 0);
        chk("mw0_exmem_en", int'(exmem_en), 0);
        chk("mw0_bubble", int'(memwb_bubble), 1);
        chk("mw0_state", int'(state), 0);
        cyc();
        chk("mw1_state", int'(state), 1);
        chk("mw1_idex_en", int'(idex_en), 0);
        chk("mw1_dmem_req", int'(dmem_req), 1);
        cyc();
        chk("mw2_state", int'(state), 1);
        chk("mw2_bubble", int'(memwb_bubble), 1);
        cyc();
        dmem_ready = 1; exmem_branch_taken = 1;
        #1;
        chk("mwrel_state", int'(state), 1);
        chk("mwrel_pc_en", int'(pc_en), 1);
        chk("mwrel_exmem_en", int'(exmem_en), 1);
        chk("mwrel_bubble", int'(memwb_bubble), 0);
        chk("mwrel_ifid_flush", int'(ifid_flush), 1);
        cyc();
        chk("mwdone_state", int'(state), 0);
        chk("mwdone_stall_cnt", int'(stall_cnt), 3);
        chk("mwdone_flush_cnt", int'(flush_cnt), 1);
        // timeout with saturating stall counter
        pulse_reset();
        exmem_mem_access = 1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            chk($sformatf("to_wait%0d_state", i), int'(state), 1);
            chk($sformatf("to_wait%0d_mem_err", i), int'(mem_err), 0);
        end
        cyc();
        chk("to_err_state", int'(state), 2);
        chk("to_err_mem_err", int'(mem_err), 1);
        chk("to_err_dmem_req", int'(dmem_req), 0);
        chk("to_err_exmem_flush", int'(exmem_flush), 1);
        chk("to_err_bubble", int'(memwb_bubble), 1);
        chk("to_err_pc_en", int'(pc_en), 1);
        chk("to_sat_stall_cnt", int'(stall_cnt), 3);
        cyc();
        chk("to_back_state", int'(state), 0);
        chk("to_back_mem_err", int'(mem_err), 1);
        cyc();
        chk("to_rewait_state", int'(state), 1);
        chk("to_hold_stall_cnt", int'(stall_cnt), 3);
        // asynchronous reset in the middle of a wait
        #3;
        reset = 1;
        #1;
        chk("ar_state", int'(state), 0);
        chk("ar_mem_err", int'(mem_err), 0);
        chk("ar_stall_cnt", int'(stall_cnt), 0);
        chk("ar_pc_en", int'(pc_en), 0);
        chk("ar_dmem_req", int'(dmem_req), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Detects load-use hazards and inserts one bubble.
- Squashes wrong-path instructions on a taken branch resolved in MEM.
- Freezes the pipeline while a variable-latency data memory completes a req/ready handshake.
- Keeps saturating performance counters and a sticky memory-timeout flag.
- Sits beside the pipeline registers and drives their enable/flush inputs and the PC enable.

Parameters:
- CNT_W, 16, width of the stall and flush counters (saturating).
- MEM_TIMEOUT, 64, maximum MEM_WAIT cycles before the controller aborts the wait and sets mem_err.
- TO_W, 7, width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- id_rs1  in  5  rs1 of the instruction in IF/ID
- id_rs2  in  5  rs2 of the instruction in IF/ID
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch)
- idex_mem_read  in  1  ID/EX holds a load
- idex_rd  in  5  rd in ID/EX
- exmem_branch_taken  in  1  EX/MEM branch AND zero
- exmem_mem_access  in  1  EX/MEM MemRead OR MemWrite
- dmem_ready  in  1  data memory completion strobe
- dmem_req  out  1  data memory request
- pc_en  out  1  PC load enable
- ifid_en  out  1  IF/ID write enable
- idex_en  out  1  ID/EX write enable
- exmem_en  out  1  EX/MEM write enable
- ifid_flush  out  1  IF/ID clear to NOP on next edge
- idex_flush  out  1  ID/EX clear control bits on next edge
- exmem_flush  out  1  EX/MEM clear control bits on next edge
- memwb_bubble  out  1  MEM/WB captures RegWrite=0 on next edge
- state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 ERR_RECOVER
- stall_cnt  out  CNT_W  cycles with pc_en=0
- flush_cnt  out  CNT_W  taken-branch flush events
- mem_err  out  1  sticky timeout flag

Behaviour:
Reset (async):
- state=RUN; wait_cnt, stall_cnt, flush_cnt, mem_err = 0.
- While reset is high, all enables=0, flushes=0, dmem_req=0, memwb_bubble=0.

Timing:
- All control outputs are combinational from state plus inputs, effective at the next clk edge (zero-cycle latency).
- Counters, state and mem_err are registered.

Default in RUN: all enables=1, flushes=0, memwb_bubble=0.

Priority, high to low: memory stall > branch flush > load-use.

dmem_req:
- dmem_req = exmem_mem_access in RUN and MEM_WAIT; 0 in ERR_RECOVER.
- dmem_req is held stable until dmem_ready.

RUN:
- Memory stall: exmem_mem_access=1 and dmem_ready=0.
  - pc_en, ifid_en, idex_en, exmem_en = 0; memwb_bubble=1.
  - Next state MEM_WAIT, wait_cnt=1.
  - If dmem_ready=1 in the same cycle, there is no stall.
- Else if exmem_branch_taken:
  - ifid_flush = idex_flush = exmem_flush = 1; pc_en=1 (target loads).
  - flush_cnt increments.
  - Load-use is ignored this cycle.
- Else if load-use: idex_mem_read AND idex_rd!=0 AND (idex_rd==id_rs1 OR (id_uses_rs2 AND idex_rd==id_rs2)).
  - pc_en=0, ifid_en=0, idex_flush=1; the hazard resolves next cycle.

MEM_WAIT:
- Frozen outputs as in the RUN memory-stall case.
- wait_cnt increments each cycle.
- dmem_ready=1: release the freeze this cycle (enables=1, memwb_bubble=0) and go to RUN.
  - A branch or load-use condition present that cycle is evaluated as in RUN.
- wait_cnt==MEM_TIMEOUT and no ready: set mem_err and go to ERR_RECOVER.

ERR_RECOVER (one cycle):
- exmem_flush=1, memwb_bubble=1, dmem_req=0; other enables=1 (the faulting access is dropped).
- Next state RUN.

Counters:
- stall_cnt increments on every cycle with pc_en=0, excluding reset.
- Both counters saturate at all-ones; no wrap.
- mem_err clears only on reset.
- State encoding 3 is illegal and returns to RUN.

Decomposition:
- Shared package pipeline_ctrl_pkg: state enum (RUN, MEM_WAIT, ERR_RECOVER), REG_ZERO=5'd0, and the default MEM_TIMEOUT constant.
- One sub-module, sat_counter (parameter W; inputs clk, reset, inc; output cnt), instantiated twice.
- Hazard compare logic stays inline.

Test Plan:
1. Load-use: idex_mem_read=1, idex_rd=5, id_rs1=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; stall_cnt 0->1. Repeat with idex_rd=0 -> no stall.
2. rs2 gating: idex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall; with id_uses_rs2=1 -> stall.
3. Branch over load-use: exmem_branch_taken=1 with a concurrent load-use -> all three flushes=1, pc_en=1, flush_cnt=1, no stall.
4. Memory wait: exmem_mem_access=1, dmem_ready low for 3 cycles then high -> state=MEM_WAIT for 3 cycles, enables=0 and memwb_bubble=1 in those cycles, release on the ready cycle, stall_cnt=3.
5. Timeout: MEM_TIMEOUT=4, dmem_ready never asserted -> mem_err=1 after 4 wait cycles, one ERR_RECOVER cycle with dmem_req=0 and exmem_flush=1, then RUN.
6. Async reset mid-MEM_WAIT -> state=RUN, counters=0, mem_err=0, enables=0 immediately without waiting for a clk edge. Saturation check: CNT_W=2, 5 stalls -> stall_cnt holds at 3.
